// File: rtl/freq_div_pkg.sv
// Shared constants and helpers for the freq_div clock divider.
package freq_div_pkg;

  // Default integer division ratio.
  localparam int unsigned FREQ_DIV_DEFAULT = 10;

  // Ceiling log2. Returns at least 1 so a counter is never zero bits wide.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage : freq_div_pkg

// File: rtl/freq_div_cnt.sv
// Modulo-DIV counter: counts 0..DIV-1 and flags the terminal count.
module freq_div_cnt
  import freq_div_pkg::*;
#(
  parameter int unsigned DIV   = FREQ_DIV_DEFAULT,
  parameter int unsigned CNT_W = clog2(DIV)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Terminal count decode; the next edge wraps the counter to zero.
  assign wrap_o = (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  // Next count: increment, or wrap to zero at DIV-1.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (wrap_o) begin
      cnt_d = '0;
    end
  end

  // Counter register, held at zero while reset is asserted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : freq_div_cnt

// File: rtl/freq_div.sv
// Integer clock divider producing clk_o = clk_i / DIV plus a once-per-period
// tick_o pulse aligned with the clk_o falling edge.
// Optional macro FREQ_DIV_ODD_DUTY50_EN: for odd DIV, a negedge flop stretches
// the clk_o low phase by half a clk_i cycle to give exact 50% duty.
module freq_div
  import freq_div_pkg::*;
#(
  parameter int unsigned DIV = FREQ_DIV_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic clk_o,
  output logic tick_o
);

  localparam int unsigned      CNT_W  = clog2(DIV);
  localparam logic [CNT_W-1:0] SET_AT = CNT_W'(DIV / 2 - 1);

  // Ratios below 2 have no meaningful divided clock.
  if (DIV < 2) begin : g_div_check
    $error("freq_div: DIV must be at least 2");
  end

  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             q_pos_q;
  logic             q_pos_d;
  logic             tick_q;
  logic             tick_d;

  freq_div_cnt #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .cnt_o  (cnt),
    .wrap_o (wrap)
  );

  // Rise at the half-period count, fall at the terminal count; tick follows wrap.
  always_comb begin
    q_pos_d = q_pos_q;
    tick_d  = wrap;
    if (wrap) begin
      q_pos_d = 1'b0;
    end else if (cnt == SET_AT) begin
      q_pos_d = 1'b1;
    end
  end

  // Divided-clock and tick registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      q_pos_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      q_pos_q <= q_pos_d;
      tick_q  <= tick_d;
    end
  end

  assign tick_o = tick_q;

`ifdef FREQ_DIV_ODD_DUTY50_EN
  if (DIV % 2 == 1) begin : g_odd_duty
    logic q_neg_q;

    // Half-cycle delayed copy of q_pos; ANDing trims the rising edge by half a cycle.
    always_ff @(negedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        q_neg_q <= 1'b0;
      end else begin
        q_neg_q <= q_pos_q;
      end
    end

    assign clk_o = q_pos_q & q_neg_q;
  end else begin : g_even_duty
    assign clk_o = q_pos_q;
  end
`else
  assign clk_o = q_pos_q;
`endif

endmodule : freq_div

// File: tb/tb_freq_div.sv
// Directed self-checking bench for freq_div at DIV = 10, 2 and 5.
module tb_freq_div;

  logic clk;
  logic rst;
  logic c10, t10, c2, t2, c5, t5;

  int total;
  int bad;
  int edges10;

  // Per-edge expectations, bit k-1 = value just after clk rising edge k
  // (counting from reset release).
  logic [19:0] exp_c10;
  logic [19:0] exp_t10;
  logic [19:0] exp_c2;
  logic [19:0] exp_t2;
  logic [19:0] exp_c5_pos;
  logic [19:0] exp_c5_neg;
  logic [19:0] exp_t5;

  freq_div #(.DIV(10)) u10 (.clk_i(clk), .rst_i(rst), .clk_o(c10), .tick_o(t10));
  freq_div #(.DIV(2))  u2  (.clk_i(clk), .rst_i(rst), .clk_o(c2),  .tick_o(t2));
  freq_div #(.DIV(5))  u5  (.clk_i(clk), .rst_i(rst), .clk_o(c5),  .tick_o(t5));

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Counts every transition of the DIV=10 output to expose glitches.
  always @(c10) edges10++;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    #5;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #5;
    rst = 1'b0;
    #85;
    total++;
    if ({c10, t10, c2, t2, c5, t5} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 000000", {c10, t10, c2, t2, c5, t5});
    end
    total++;
    if (u10.u_cnt.cnt_o !== 4'd0) begin
      bad++;
      $display("FAIL reset_cnt10: got %0d want 0", u10.u_cnt.cnt_o);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_waveforms();
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (c10 !== exp_c10[k-1] || t10 !== exp_t10[k-1]) begin
        bad++;
        $display("FAIL div10_pos edge %0d: clk_o=%b tick_o=%b want %b %b",
                 k, c10, t10, exp_c10[k-1], exp_t10[k-1]);
      end
      total++;
      if (c2 !== exp_c2[k-1] || t2 !== exp_t2[k-1]) begin
        bad++;
        $display("FAIL div2_pos edge %0d: clk_o=%b tick_o=%b want %b %b",
                 k, c2, t2, exp_c2[k-1], exp_t2[k-1]);
      end
      total++;
      if (c5 !== exp_c5_pos[k-1] || t5 !== exp_t5[k-1]) begin
        bad++;
        $display("FAIL div5_pos edge %0d: clk_o=%b tick_o=%b want %b %b",
                 k, c5, t5, exp_c5_pos[k-1], exp_t5[k-1]);
      end
      @(negedge clk);
      #1;
      total++;
      if (c10 !== exp_c10[k-1] || c2 !== exp_c2[k-1] || c5 !== exp_c5_neg[k-1]) begin
        bad++;
        $display("FAIL neg_phase after edge %0d: clk10/2/5=%b%b%b want %b%b%b",
                 k, c10, c2, c5, exp_c10[k-1], exp_c2[k-1], exp_c5_neg[k-1]);
      end
    end
  endtask

  task automatic test_mid_reset();
    pulse_reset();
    for (int k = 1; k <= 6; k++) @(posedge clk);
    #1;
    total++;
    if (c10 !== 1'b1) begin
      bad++;
      $display("FAIL midrst_prehigh: clk_o=%b want 1", c10);
    end
    #5;
    rst = 1'b0;
    #2;
    total++;
    if ({c10, t10, c2, t2, c5, t5} !== 6'b0) begin
      bad++;
      $display("FAIL midrst_async: got %b want 000000", {c10, t10, c2, t2, c5, t5});
    end
    total++;
    if (u10.u_cnt.cnt_o !== 4'd0) begin
      bad++;
      $display("FAIL midrst_cnt: got %0d want 0", u10.u_cnt.cnt_o);
    end
    #8;
    rst = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (c10 !== exp_c10[k-1] || t10 !== exp_t10[k-1]) begin
        bad++;
        $display("FAIL midrst_restart edge %0d: clk_o=%b tick_o=%b want %b %b",
                 k, c10, t10, exp_c10[k-1], exp_t10[k-1]);
      end
    end
  endtask

  task automatic test_tick_count();
    int ticks;
    logic prev_c;
    pulse_reset();
    ticks   = 0;
    prev_c  = c10;
    edges10 = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (t10 === 1'b1) begin
        ticks++;
        total++;
        if (!(prev_c === 1'b1 && c10 === 1'b0)) begin
          bad++;
          $display("FAIL tick_align edge %0d: clk_o %b->%b want 1->0", k, prev_c, c10);
        end
      end
      prev_c = c10;
    end
    total++;
    if (ticks != 10) begin
      bad++;
      $display("FAIL tick_count: got %0d want 10", ticks);
    end
    total++;
    if (edges10 != 20) begin
      bad++;
      $display("FAIL clk_transitions: got %0d want 20", edges10);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    edges10 = 0;
    rst     = 1'b1;
    exp_c10    = 20'h7C1F0;
    exp_t10    = 20'h80200;
    exp_c2     = 20'h55555;
    exp_t2     = 20'hAAAAA;
    exp_c5_neg = 20'h739CE;
    exp_t5     = 20'h84210;
`ifdef FREQ_DIV_ODD_DUTY50_EN
    exp_c5_pos = 20'h6318C;
`else
    exp_c5_pos = 20'h739CE;
`endif
    test_reset();
    test_waveforms();
    test_mid_reset();
    test_tick_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_freq_div

// File: doc/freq_div.md
FREQ_DIV -- requirements
Module: freq_div

Interface
REQ-001 The block SHALL have parameter DIV, default 10, meaning the integer input-to-output clock division ratio.
REQ-002 The block SHALL have localparam CNT_W, equal to clog2(DIV), meaning the counter width.
REQ-003 The block SHALL have port clk_i, input, 1 bit, the single source clock; all state changes on its rising edge unless stated otherwise.
REQ-004 The block SHALL have port rst_i, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have port clk_o, output, 1 bit, the divided clock with period DIV x clk_i period.
REQ-006 The block SHALL have port tick_o, output, 1 bit, a registered one-clk_i-cycle pulse once per clk_o period.

Function
REQ-007 The block SHALL hold an internal counter cnt[CNT_W-1:0] that counts 0..DIV-1 and wraps from DIV-1 to 0 on the next rising edge.
REQ-008 clk_o SHALL come from a register q_pos that is set when cnt == DIV/2-1 (integer division) and cleared when cnt == DIV-1.
REQ-009 For even DIV, clk_o SHALL be high for exactly DIV/2 input cycles and low for DIV/2 input cycles (50% duty).
REQ-010 For odd DIV with REQ-021 disabled, clk_o SHALL be high for (DIV+1)/2 input cycles and low for (DIV-1)/2 input cycles.
REQ-011 After reset release, the first clk_o rising edge SHALL follow the (DIV/2)-th rising edge of clk_i.
REQ-012 tick_o SHALL be 1 for exactly the clk_i cycle that follows the edge where cnt == DIV-1, coincident with the clk_o falling edge.
REQ-013 For DIV == 2, clk_o SHALL toggle on every rising edge of clk_i and tick_o SHALL pulse every second cycle.
REQ-014 DIV < 2 SHALL cause an elaboration-time error; no runtime behaviour is defined for it.
REQ-015 The block SHALL produce no glitches on clk_o; clk_o SHALL be driven directly from flops, or from an AND of two flops per REQ-021.

Reset
REQ-016 While rst_i == 0, cnt SHALL be 0, clk_o SHALL be 0 and tick_o SHALL be 0, asynchronously and without waiting for a clock edge.
REQ-017 Assertion of rst_i mid-period SHALL immediately force the REQ-016 values and abandon the current period.
REQ-018 After rst_i deasserts, counting SHALL restart from 0 on the first rising edge of clk_i.
REQ-019 Any negedge-clocked flop introduced by REQ-021 SHALL also reset asynchronously to 0.

Configuration
REQ-020 Macro FREQ_DIV_ODD_DUTY50_EN SHALL control an odd-DIV duty-cycle correction.
REQ-021 With FREQ_DIV_ODD_DUTY50_EN defined and DIV odd: a flop q_neg SHALL sample q_pos on the falling edge of clk_i, and clk_o SHALL equal q_pos AND q_neg. This gives high for DIV/2 cycles plus one half cycle, exact 50% duty, and a rising edge delayed half a clk_i cycle relative to REQ-011.
REQ-022 Without FREQ_DIV_ODD_DUTY50_EN, or with DIV even, clk_o SHALL equal q_pos and the design SHALL contain no negedge flop.

Structure
REQ-023 Package freq_div_pkg SHALL hold the constant-function clog2 and the constant FREQ_DIV_DEFAULT = 10.
REQ-024 The modulo counter SHALL be a sub-module freq_div_cnt (parameters DIV and CNT_W; ports clk_i, rst_i, cnt_o, wrap_o); freq_div SHALL instantiate it once.

Verification
REQ-025 DIV=10, clk_i period 40 ns, rst_i low for 100 ns then high -> clk_o period 400 ns, high 200 ns, first rise at the 5th clk_i rising edge after release.
REQ-026 DIV=2 -> clk_o toggles every clk_i rising edge (period 80 ns); tick_o high 40 ns every 80 ns.
REQ-027 DIV=5 without the macro -> clk_o high 120 ns, low 80 ns; with FREQ_DIV_ODD_DUTY50_EN -> clk_o high 100 ns, low 100 ns.
REQ-028 rst_i pulsed low for 10 ns in the middle of a clk_o high phase -> clk_o and tick_o drop to 0 within the pulse without a clock edge, and the period restarts per REQ-011.
REQ-029 DIV=10 run for 100 clk_i cycles -> exactly 10 tick_o pulses, each aligned with a clk_o falling edge, and no clk_o glitches.
